// File: rtl/serial_pkg.sv
// serial_pkg
// Definitions shared by both ends of the serial pattern link: the transmitter
// FSM state encoding and the reference pattern that the detector looks for.
// Ports: none (package only).
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic [4:0] DETECT_PATTERN_01110 = 5'b01110;

endpackage

// File: rtl/serial_pattern_gen_if.sv
// serial_pattern_gen_if
// Request/status bundle of the serial pattern transmitter.
// Ports (signals):
//   start, use_default, pattern[WIDTH], repeat_n[REP_W], abort : requester -> generator
//   a, valid, busy, done                                       : generator -> requester/line
// Modports: master (requester side), slave (generator side).
interface serial_pattern_gen_if #(
    parameter int WIDTH = 5,
    parameter int REP_W = 4
);

    logic             start;
    logic             use_default;
    logic [WIDTH-1:0] pattern;
    logic [REP_W-1:0] repeat_n;
    logic             abort;
    logic             a;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output start, use_default, pattern, repeat_n, abort,
        input  a, valid, busy, done
    );

    modport slave (
        input  start, use_default, pattern, repeat_n, abort,
        output a, valid, busy, done
    );

endinterface

// File: rtl/serial_pattern_gen_shift_reg.sv
// pattern_shift_reg
// WIDTH-bit parallel-load shift register that shifts toward the MSB and
// presents its MSB as the serial output. Load has priority over shift.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture load_data on the next edge
//   shift      : shift left by one (zero filled) on the next edge
//   load_data  : parallel value to load
//   msb_out    : current MSB
module pattern_shift_reg #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             msb_out
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_data;
        end else if (shift) begin
            data_d = {data_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign msb_out = data_q[WIDTH-1];

endmodule

// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen
// Serial transmitter: sends a WIDTH-bit pattern MSB first, one bit per clock,
// repeated REPEAT+1 times back to back, then pulses DONE for one cycle.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : serial_pattern_gen_if.slave (start/use_default/pattern/
//              repeat_n/abort in; a/valid/busy/done out, all registered)
module serial_pattern_gen
    import serial_pkg::*;
#(
    parameter int               WIDTH           = 5,
    parameter logic [WIDTH-1:0] DEFAULT_PATTERN = WIDTH'(DETECT_PATTERN_01110),
    parameter logic             IDLE_LEVEL      = 1'b1,
    parameter int               REP_W           = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_pattern_gen_if.slave bus
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [REP_W-1:0] rep_lim_q, rep_lim_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic             a_q, a_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sr_load;
    logic             sr_shift;
    logic [WIDTH-1:0] sr_load_data;
    logic             sr_msb;
    logic [WIDTH-1:0] sel_pattern;

    assign sel_pattern = bus.use_default ? DEFAULT_PATTERN : bus.pattern;

    // The shift register holds the bits still to be sent after the one on A,
    // so its MSB is always the next bit and A itself stays a plain flop.
    pattern_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (sr_load),
        .shift     (sr_shift),
        .load_data (sr_load_data),
        .msb_out   (sr_msb)
    );

    // Next-state and next-output logic; outputs fall back to the idle values.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rep_cnt_d    = rep_cnt_q;
        rep_lim_d    = rep_lim_q;
        pat_d        = pat_q;
        a_d          = IDLE_LEVEL;
        valid_d      = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        sr_load      = 1'b0;
        sr_shift     = 1'b0;
        sr_load_data = {pat_q[WIDTH-2:0], 1'b0};

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    pat_d        = sel_pattern;
                    rep_lim_d    = bus.repeat_n;
                    bit_cnt_d    = '0;
                    rep_cnt_d    = '0;
                    sr_load      = 1'b1;
                    sr_load_data = {sel_pattern[WIDTH-2:0], 1'b0};
                    a_d          = sel_pattern[WIDTH-1];
                    valid_d      = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = ST_SEND;
                end
            end

            ST_SEND: begin
                if (bus.abort) begin
                    bit_cnt_d = '0;
                    rep_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else if (bit_cnt_q == LAST_BIT) begin
                    // Compare before increment so an all-ones limit cannot wrap.
                    if (rep_cnt_q < rep_lim_q) begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                        bit_cnt_d = '0;
                        sr_load   = 1'b1;
                        a_d       = pat_q[WIDTH-1];
                        valid_d   = 1'b1;
                        busy_d    = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_FINISH;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    sr_shift  = 1'b1;
                    a_d       = sr_msb;
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                end
            end

            ST_FINISH: begin
                bit_cnt_d = '0;
                rep_cnt_d = '0;
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            rep_lim_q <= '0;
            pat_q     <= '0;
            a_q       <= IDLE_LEVEL;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            rep_lim_q <= rep_lim_d;
            pat_q     <= pat_d;
            a_q       <= a_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.a     = a_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: doc/serial_pattern_gen.md
Name: serial_pattern_gen

Overview:
Serial transmitter that emits a programmable WIDTH-bit pattern, MSB first, one bit per clock on a single serial line. It is the stimulus/transmit end of the serial pattern-detector link: its output A drives a detector's serial input directly. Each transmission is started by a one-cycle START request and can repeat the pattern back-to-back; status is reported through BUSY/VALID/DONE.

Parameters:
WIDTH, 5, pattern length in bits (2..16)
DEFAULT_PATTERN, 5'b01110, pattern used when USE_DEFAULT=1 at START
IDLE_LEVEL, 1'b1, level driven on A when not transmitting (1 keeps a 0-leading detector in its initial state)
REP_W, 4, width of the REPEAT field

Ports:
CLK  input  1  system clock, all state changes on rising edge
RESET  input  1  asynchronous, active-high reset
START  input  1  transmit request, sampled only in IDLE
USE_DEFAULT  input  1  1: send DEFAULT_PATTERN, 0: send PATTERN
PATTERN  input  WIDTH  pattern to send, latched at accepted START
REPEAT  input  REP_W  extra repetitions; total sends = REPEAT+1, latched at START
ABORT  input  1  synchronous cancel of a transmission in progress
A  output  1  serial data line
VALID  output  1  high in every cycle where A carries a pattern bit
BUSY  output  1  high from the cycle after START acceptance through the DONE cycle
DONE  output  1  one-cycle pulse after the final bit of the final repetition

Behaviour:
- One clock domain, CLK. RESET is asynchronous and active-high; when asserted: state=IDLE, A=IDLE_LEVEL, VALID=0, BUSY=0, DONE=0, counters=0. All outputs are registered.
- States: IDLE, SEND, FINISH.
- IDLE: A=IDLE_LEVEL, VALID=0. START=1 at an edge latches the pattern (PATTERN, or DEFAULT_PATTERN if USE_DEFAULT=1) into the shift register, latches REPEAT, clears bit_cnt, and moves to SEND.
- SEND: in the cycle after acceptance, A=pattern[WIDTH-1] with VALID=1 and BUSY=1. Each edge advances one bit, MSB to LSB.
  - When bit_cnt reaches WIDTH-1: if rep_cnt < latched REPEAT, increment rep_cnt, reload the latched pattern, and send its MSB in the very next cycle. There is no gap between repetitions.
  - Otherwise go to FINISH.
- FINISH: A=IDLE_LEVEL, VALID=0, BUSY=1, DONE=1 for exactly one cycle, then IDLE.
- Latency: START accepted at edge k gives first bit in cycle k+1 and last bit in cycle k+WIDTH*(REPEAT+1). DONE is high in the following cycle.
- Earliest restart: the next START is accepted at the edge ending the first IDLE cycle after FINISH.
- START while in SEND or FINISH is ignored and not queued. PATTERN, REPEAT and USE_DEFAULT changes after acceptance have no effect.
- ABORT=1 in SEND: next edge goes to IDLE, so A=IDLE_LEVEL, VALID=0, BUSY=0, and DONE is not pulsed. ABORT has no effect in IDLE or FINISH. If START and ABORT are both high in IDLE, START wins.
- RESET mid-transmission: immediate return to reset values, with no DONE.
- Width rules:
  - bit_cnt is $clog2(WIDTH) bits and compares against WIDTH-1, so it does not rely on natural wrap.
  - rep_cnt is REP_W bits. REPEAT=all-ones gives 2^REP_W sends with no overflow, because the compare happens before the increment.

Decomposition:
- Shared package/header serial_pkg: state encodings (ST_IDLE, ST_SEND, ST_FINISH) and DETECT_PATTERN_01110 (5'b01110), shared with the detector side.
- One natural sub-module: pattern_shift_reg. It is a WIDTH-bit parallel-load, MSB-out shift register with load/shift enables and asynchronous reset.
- The FSM and counters stay in serial_pattern_gen.

Test Plan:
- Reset: assert RESET mid-cycle with no clock edge -> A=1, VALID=0, BUSY=0, DONE=0 immediately; same result when RESET is asserted during SEND.
- Single send: USE_DEFAULT=1, REPEAT=0, START pulse at edge k -> A=0,1,1,1,0 in cycles k+1..k+5 with VALID=1; DONE=1 in cycle k+6; BUSY low in cycle k+7. A connected detector asserts Y once.
- Repeat: PATTERN=5'b10011, USE_DEFAULT=0, REPEAT=2 -> 15 contiguous bits 10011 10011 10011 with VALID unbroken; DONE in cycle k+16.
- Ignored request: hold START high for the whole transmission and change PATTERN to 5'b11111 mid-send -> output unchanged; after DONE, the next START (still high) is accepted in the IDLE cycle and 11111 is sent.
- Abort: ABORT=1 at the edge ending the 3rd bit -> next cycle A=1, VALID=0, BUSY=0; DONE never pulses; a following START behaves normally.
- Boundary: REPEAT=4'hF, WIDTH=5 -> exactly 80 VALID cycles, then one DONE pulse.
